// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, oversample ratio and parity helper.
// The receiver reuses these when it gains parity checking.
package uart_tx_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MAX_DBIT   = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Unused upper bits must be zero; odd = 1 selects odd parity.
  function automatic logic parity_bit(input logic [MAX_DBIT-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side write port and status of the UART transmitter.
interface uart_tx_if #(
  parameter int DBIT = 8
);
  // Handshake: a word transfers on any rising clk edge where tx_start = 1 and
  // tx_ready = 1; tx_din is sampled on that edge. tx_start with tx_ready = 0 is dropped.
  logic            tx_start;
  logic [DBIT-1:0] tx_din;
  logic            tx_ready;
  logic            tx_busy;
  logic            tx_done_tick;
  logic            tx;

  modport master (output tx_start, tx_din, input tx_ready, tx_busy, tx_done_tick, tx);
  modport slave  (input tx_start, tx_din, output tx_ready, tx_busy, tx_done_tick, tx);
endinterface

// File: rtl/uart_tx_buffer.sv
// One-entry holding register that lets the host queue the next word while a frame is on the line.
module uart_tx_buffer #(
  parameter int DBIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en_i,
  input  logic [DBIT-1:0] wr_data_i,
  input  logic            rd_en_i,
  output logic [DBIT-1:0] rd_data_o,
  output logic            full_o,
  output logic            ready_o
);

  logic            full_q, full_d;
  logic [DBIT-1:0] data_q, data_d;

  // Ready reflects the flag before any same-cycle drain, so a full buffer rejects writes.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (rd_en_i) full_d = 1'b0;
    if (wr_en_i && !full_q) begin
      full_d = 1'b1;
      data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign rd_data_o = data_q;
  assign full_o    = full_q;
  assign ready_o   = !full_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB first, optional parity, SB_TICK-tick stop,
// paced by a 16x s_tick strobe, with a one-word holding buffer for gapless streaming.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_tick,
  uart_tx_if.slave   bus,
  output tx_state_e  state_o
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  tx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;

  logic            buf_full, buf_ready, buf_wr, buf_rd, accept, done;
  logic [DBIT-1:0] buf_data, load_data;

  assign accept    = bus.tx_start && buf_ready;
  assign buf_wr    = accept && (state_q != ST_IDLE);
  assign load_data = buf_full ? buf_data : bus.tx_din;

  uart_tx_buffer #(.DBIT(DBIT)) u_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (buf_wr),
    .wr_data_i (bus.tx_din),
    .rd_en_i   (buf_rd),
    .rd_data_o (buf_data),
    .full_o    (buf_full),
    .ready_o   (buf_ready)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    par_d   = par_q;
    buf_rd  = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A word left in the buffer by a write on the final stop tick starts from here.
        if (buf_full || accept) begin
          buf_rd  = buf_full;
          shift_d = load_data;
          par_d   = parity_bit(MAX_DBIT'(load_data), PARITY_ODD != 0);
          s_d     = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else s_d = s_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_LAST) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            else n_d = n_q + 1'b1;
          end else s_d = s_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else s_d = s_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            done = 1'b1;
            s_d  = '0;
            if (buf_full) begin
              buf_rd  = 1'b1;
              shift_d = buf_data;
              par_d   = parity_bit(MAX_DBIT'(buf_data), PARITY_ODD != 0);
              state_d = ST_START;
            end else state_d = ST_IDLE;
          end else s_d = s_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tx is derived from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = (state_q != ST_IDLE);
  assign bus.tx_ready     = buf_ready;
  assign bus.tx_done_tick = done;
  assign state_o          = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1, even/odd parity and 2-stop-bit instances on one tick source.
module tb_uart_tx;
  import uart_tx_pkg::*;

  logic clk, rst_n, s_tick;
  int   checks, errors, done_cnt;

  typedef struct packed {
    logic [7:0] data;
    logic       start_bit;
    logic       stop_bit;
    logic       done_at_end;
    logic       no_gap;
  } frame_t;
  frame_t mon_q[$];

  tx_state_e st0, st_pe, st_po, st_sb;

  uart_tx_if #(.DBIT(8)) bus0 ();
  uart_tx_if #(.DBIT(8)) bus_pe ();
  uart_tx_if #(.DBIT(8)) bus_po ();
  uart_tx_if #(.DBIT(8)) bus_sb ();

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .bus(bus0), .state_o(st0));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .bus(bus_pe), .state_o(st_pe));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_po (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .bus(bus_po), .state_o(st_po));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_sb (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .bus(bus_sb), .state_o(st_sb));

  // ---------------- clock / reset / tick source ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : tick_gen
    int cnt;
    cnt    = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (cnt == 3);
      cnt    = (cnt == 3) ? 0 : cnt + 1;
    end
  end

  // ---------------- 8N1 line monitor on bus0 ----------------
  // Tick k is the k-th s_tick seen at a negedge after tx falls; bit b is sampled at tick 16*b+8.
  initial begin : monitor
    int       tcnt;
    logic     active, prev_end;
    logic [2:0] bi;
    frame_t   f;
    active   = 1'b0;
    prev_end = 1'b0;
    done_cnt = 0;
    tcnt     = 0;
    f        = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active   = 1'b0;
        prev_end = 1'b0;
      end else begin
        if (bus0.tx_done_tick) done_cnt++;
        if (!active) begin
          if (bus0.tx == 1'b0) begin
            active   = 1'b1;
            tcnt     = 0;
            f        = '0;
            f.no_gap = prev_end;
          end
          prev_end = 1'b0;
        end
        if (active && s_tick) begin
          tcnt++;
          if (tcnt == 8) f.start_bit = bus0.tx;
          else if (tcnt == 152) f.stop_bit = bus0.tx;
          else if (tcnt % 16 == 8) begin
            bi = 3'((tcnt - 24) / 16);
            f.data[bi] = bus0.tx;
          end
          if (tcnt == 160) begin
            f.done_at_end = bus0.tx_done_tick;
            mon_q.push_back(f);
            active   = 1'b0;
            prev_end = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send0(input logic [7:0] d, output logic acc);
    @(posedge clk);
    #1;
    bus0.tx_start = 1'b1;
    bus0.tx_din   = d;
    acc           = bus0.tx_ready;
    @(posedge clk);
    #1;
    bus0.tx_start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string what);
    int cyc;
    cyc = 0;
    while (mon_q.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (mon_q.size() < n) begin
      errors++;
      $display("FAIL %s: frames seen %0d, required %0d", what, mon_q.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus0.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, want 1", bus0.tx); end
    checks++; if (bus0.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, want 1", bus0.tx_ready); end
    checks++; if (bus0.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", bus0.tx_busy); end
    checks++; if (bus0.tx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, want 0", bus0.tx_done_tick); end
    checks++; if (st0 !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d, want %0d", st0, ST_IDLE); end
    checks++; if (bus_sb.tx !== 1'b1) begin errors++; $display("FAIL reset_tx_sb: got %b, want 1", bus_sb.tx); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic acc;
    int   d0;
    mon_q.delete();
    d0 = done_cnt;
    checks++; if (bus0.tx !== 1'b1) begin errors++; $display("FAIL single_idle_tx: got %b, want 1", bus0.tx); end
    send0(8'hA5, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: ready %b, want 1", acc); end
    checks++; if (bus0.tx !== 1'b0) begin errors++; $display("FAIL single_latency: tx %b one clock after accept, want 0", bus0.tx); end
    checks++; if (bus0.tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, want 1", bus0.tx_busy); end
    wait_frames(1, "single_frame");
    repeat (100) @(negedge clk);
    if (mon_q.size() >= 1) begin
      checks++; if (mon_q[0].data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h, want a5", mon_q[0].data); end
      checks++; if (mon_q[0].start_bit !== 1'b0 || mon_q[0].stop_bit !== 1'b1) begin
        errors++; $display("FAIL single_framing: start %b stop %b, want 0 1", mon_q[0].start_bit, mon_q[0].stop_bit); end
      checks++; if (mon_q[0].done_at_end !== 1'b1) begin errors++; $display("FAIL single_done_tick160: got %b, want 1", mon_q[0].done_at_end); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_count: got %0d, want 1", done_cnt - d0); end
    checks++; if (bus0.tx_busy !== 1'b0 || bus0.tx !== 1'b1) begin
      errors++; $display("FAIL single_return_idle: busy %b tx %b, want 0 1", bus0.tx_busy, bus0.tx); end
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   d0, cyc;
    mon_q.delete();
    d0 = done_cnt;
    send0(8'h55, acc);
    send0(8'h0F, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept2: ready %b, want 1", acc); end
    checks++; if (bus0.tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %b, want 0", bus0.tx_ready); end
    cyc = 0;
    while (mon_q.size() < 1 && cyc < 3000) begin @(negedge clk); cyc++; end
    @(posedge clk);
    #1;
    checks++; if (bus0.tx_ready !== 1'b1 || bus0.tx_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_drain: ready %b busy %b, want 1 1", bus0.tx_ready, bus0.tx_busy); end
    wait_frames(2, "b2b_frames");
    repeat (100) @(negedge clk);
    if (mon_q.size() >= 2) begin
      checks++; if (mon_q[0].data !== 8'h55 || mon_q[1].data !== 8'h0F) begin
        errors++; $display("FAIL b2b_data: got %h %h, want 55 0f", mon_q[0].data, mon_q[1].data); end
      checks++; if (mon_q[1].no_gap !== 1'b1) begin errors++; $display("FAIL b2b_no_gap: got %b, want 1", mon_q[1].no_gap); end
      checks++; if (mon_q[1].done_at_end !== 1'b1 || mon_q[1].stop_bit !== 1'b1) begin
        errors++; $display("FAIL b2b_frame2_end: done %b stop %b, want 1 1", mon_q[1].done_at_end, mon_q[1].stop_bit); end
    end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d, want 2", done_cnt - d0); end
  endtask

  task automatic test_overflow();
    logic acc;
    mon_q.delete();
    send0(8'h11, acc);
    send0(8'h22, acc);
    send0(8'h33, acc);
    checks++; if (acc !== 1'b0) begin errors++; $display("FAIL ovf_reject: ready %b at third write, want 0", acc); end
    wait_frames(2, "ovf_frames");
    repeat (400) @(negedge clk);
    checks++; if (mon_q.size() != 2) begin errors++; $display("FAIL ovf_frame_count: got %0d, want 2", mon_q.size()); end
    if (mon_q.size() >= 2) begin
      checks++; if (mon_q[0].data !== 8'h11 || mon_q[1].data !== 8'h22) begin
        errors++; $display("FAIL ovf_data: got %h %h, want 11 22", mon_q[0].data, mon_q[1].data); end
    end
    checks++; if (bus0.tx_busy !== 1'b0) begin errors++; $display("FAIL ovf_idle: busy %b, want 0", bus0.tx_busy); end
  endtask

  task automatic test_final_tick_write();
    logic acc;
    int   cyc;
    mon_q.delete();
    send0(8'h3A, acc);
    cyc = 0;
    @(negedge clk);
    while (bus0.tx_done_tick !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
    checks++; if (bus0.tx_done_tick !== 1'b1) begin errors++; $display("FAIL ftw_done_seen: got %b, want 1", bus0.tx_done_tick); end
    checks++; if (bus0.tx_ready !== 1'b1) begin errors++; $display("FAIL ftw_ready: got %b, want 1", bus0.tx_ready); end
    bus0.tx_start = 1'b1;
    bus0.tx_din   = 8'hC3;
    @(posedge clk);
    #1;
    bus0.tx_start = 1'b0;
    checks++; if (bus0.tx_busy !== 1'b0 || bus0.tx_ready !== 1'b0) begin
      errors++; $display("FAIL ftw_idle_buffered: busy %b ready %b, want 0 0", bus0.tx_busy, bus0.tx_ready); end
    @(posedge clk);
    #1;
    checks++; if (bus0.tx_busy !== 1'b1 || bus0.tx_ready !== 1'b1 || bus0.tx !== 1'b0) begin
      errors++; $display("FAIL ftw_restart: busy %b ready %b tx %b, want 1 1 0", bus0.tx_busy, bus0.tx_ready, bus0.tx); end
    wait_frames(2, "ftw_frames");
    if (mon_q.size() >= 2) begin
      checks++; if (mon_q[1].data !== 8'hC3 || mon_q[1].no_gap !== 1'b0) begin
        errors++; $display("FAIL ftw_frame2: data %h no_gap %b, want c3 0", mon_q[1].data, mon_q[1].no_gap); end
    end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_parity();
    int t, cyc, dpe, dpo;
    @(posedge clk);
    #1;
    bus_pe.tx_start = 1'b1; bus_pe.tx_din = 8'h07;
    bus_po.tx_start = 1'b1; bus_po.tx_din = 8'h07;
    @(posedge clk);
    #1;
    bus_pe.tx_start = 1'b0;
    bus_po.tx_start = 1'b0;
    t = 0; cyc = 0; dpe = 0; dpo = 0;
    while (t < 176 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus_pe.tx_done_tick) dpe++;
      if (bus_po.tx_done_tick) dpo++;
      if (s_tick) begin
        t++;
        if (t == 152) begin
          checks++; if (bus_pe.tx !== 1'b1) begin errors++; $display("FAIL par_even_bit: got %b, want 1", bus_pe.tx); end
          checks++; if (bus_po.tx !== 1'b0) begin errors++; $display("FAIL par_odd_bit: got %b, want 0", bus_po.tx); end
        end
        if (t == 168) begin
          checks++; if (bus_pe.tx !== 1'b1 || bus_po.tx !== 1'b1) begin
            errors++; $display("FAIL par_stop: even %b odd %b, want 1 1", bus_pe.tx, bus_po.tx); end
        end
        if (t == 176) begin
          checks++; if (bus_pe.tx_done_tick !== 1'b1 || bus_po.tx_done_tick !== 1'b1) begin
            errors++; $display("FAIL par_done_176: even %b odd %b, want 1 1", bus_pe.tx_done_tick, bus_po.tx_done_tick); end
        end
      end
    end
    checks++; if (t != 176) begin errors++; $display("FAIL par_timeout: ticks %0d, want 176", t); end
    checks++; if (dpe != 1 || dpo != 1) begin errors++; $display("FAIL par_done_count: even %0d odd %0d, want 1 1", dpe, dpo); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_stop_bits();
    int   t, cyc, dn;
    logic high_ok;
    @(posedge clk);
    #1;
    bus_sb.tx_start = 1'b1; bus_sb.tx_din = 8'h3C;
    @(posedge clk);
    #1;
    bus_sb.tx_din = 8'h81;
    @(posedge clk);
    #1;
    bus_sb.tx_start = 1'b0;
    t = 0; cyc = 0; dn = 0; high_ok = 1'b1;
    while (t < 176 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus_sb.tx_done_tick) dn++;
      if (s_tick) begin
        t++;
        if (t == 144) begin
          checks++; if (bus_sb.tx !== 1'b0) begin errors++; $display("FAIL sb_last_data: got %b, want 0", bus_sb.tx); end
        end
        if (t >= 145 && bus_sb.tx !== 1'b1) high_ok = 1'b0;
      end
    end
    checks++; if (!high_ok) begin errors++; $display("FAIL sb_stop_high: stop not held high for ticks 145..176, want 1"); end
    checks++; if (dn != 1 || bus_sb.tx_done_tick !== 1'b1) begin
      errors++; $display("FAIL sb_done: count %0d at tick 176 %b, want 1 1", dn, bus_sb.tx_done_tick); end
    @(negedge clk);
    checks++; if (bus_sb.tx !== 1'b0 || bus_sb.tx_busy !== 1'b1) begin
      errors++; $display("FAIL sb_next_start: tx %b busy %b, want 0 1", bus_sb.tx, bus_sb.tx_busy); end
    cyc = 0;
    while (bus_sb.tx_busy === 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
    checks++; if (bus_sb.tx_busy !== 1'b0 || bus_sb.tx_ready !== 1'b1) begin
      errors++; $display("FAIL sb_drain: busy %b ready %b, want 0 1", bus_sb.tx_busy, bus_sb.tx_ready); end
  endtask

  task automatic test_reset_mid_frame();
    logic acc, quiet;
    int   t, cyc;
    send0(8'hF0, acc);
    send0(8'h99, acc);
    cyc = 0;
    while (st0 !== ST_DATA && cyc < 500) begin @(negedge clk); cyc++; end
    t = 0;
    while (t < 20 && cyc < 1000) begin @(negedge clk); cyc++; if (s_tick) t++; end
    checks++; if (bus0.tx !== 1'b0 || bus0.tx_ready !== 1'b0) begin
      errors++; $display("FAIL rst_pre: tx %b ready %b, want 0 0", bus0.tx, bus0.tx_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus0.tx !== 1'b1) begin errors++; $display("FAIL rst_async_tx: got %b, want 1", bus0.tx); end
    checks++; if (bus0.tx_ready !== 1'b1 || bus0.tx_busy !== 1'b0) begin
      errors++; $display("FAIL rst_async_flags: ready %b busy %b, want 1 0", bus0.tx_ready, bus0.tx_busy); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_q.delete();
    quiet = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (bus0.tx !== 1'b1 || bus0.tx_busy !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet || mon_q.size() != 0) begin
      errors++; $display("FAIL rst_no_residual: quiet %b frames %0d, want 1 0", quiet, mon_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus0.tx_start   = 1'b0; bus0.tx_din   = '0;
    bus_pe.tx_start = 1'b0; bus_pe.tx_din = '0;
    bus_po.tx_start = 1'b0; bus_po.tx_din = '0;
    bus_sb.tx_start = 1'b0; bus_sb.tx_din = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_final_tick_write();
    test_parity();
    test_stop_bits();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
